// File: rtl/r88_busctl_if.sv
// Rocket88 external bus controller: request/status and external control signals.
// The tristate data buses intD and extData stay as plain ports on the controller.
interface r88_busctl_if;
    logic [15:0] regAddr;
    logic        memReq;
    logic        memWrite;
    logic        busDrive;
    logic        memBusy;
    logic        memDone;
    logic        busErr;
    logic [15:0] extAddr;
    logic        extRdN;
    logic        extWrN;
    logic        extReady;

    modport master (
        output regAddr,
        output memReq,
        output memWrite,
        output busDrive,
        output extReady,
        input  memBusy,
        input  memDone,
        input  busErr,
        input  extAddr,
        input  extRdN,
        input  extWrN
    );

    modport slave (
        input  regAddr,
        input  memReq,
        input  memWrite,
        input  busDrive,
        input  extReady,
        output memBusy,
        output memDone,
        output busErr,
        output extAddr,
        output extRdN,
        output extWrN
    );
endinterface

// File: rtl/r88_busctl.sv
// Rocket88 external memory bus controller: strobed read/write cycles
// with minimum strobe width, wait states and timeout abort.
module r88_busctl #(
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        sysClock,
    input  logic        sysReset,
    r88_busctl_if.slave bus,
    inout  wire  [7:0]  intD,
    inout  wire  [7:0]  extData
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    localparam logic [7:0] MinW = 8'(MIN_WAIT);
    localparam logic [7:0] TOut = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        wrFlag_q, wrFlag_d;
    logic [7:0]  wrData_q, wrData_d;
    logic [7:0]  rdData_q, rdData_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        busErr_q, busErr_d;
    logic [7:0]  cntNext;
    logic        readyOk;

    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            wrFlag_q  <= 1'b0;
            wrData_q  <= 8'h00;
            rdData_q  <= 8'h00;
            waitCnt_q <= 8'h00;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrFlag_q  <= wrFlag_d;
            wrData_q  <= wrData_d;
            rdData_q  <= rdData_d;
            waitCnt_q <= waitCnt_d;
            busErr_q  <= busErr_d;
        end
    end

    // cntNext is the number of the strobe cycle ending on this edge
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wrFlag_d  = wrFlag_q;
        wrData_d  = wrData_q;
        rdData_d  = rdData_q;
        waitCnt_d = waitCnt_q;
        busErr_d  = busErr_q;
        cntNext   = waitCnt_q + 8'd1;
        readyOk   = (cntNext >= MinW) && bus.extReady;

        unique case (state_q)
            IDLE: begin
                if (bus.memReq) begin
                    addr_d   = bus.regAddr;
                    wrFlag_d = bus.memWrite;
                    busErr_d = 1'b0;
                    if (bus.memWrite) begin
                        wrData_d = intD;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                waitCnt_d = 8'h00;
                state_d   = STROBE;
            end
            STROBE: begin
                waitCnt_d = cntNext;
                if (readyOk) begin
                    if (!wrFlag_q) begin
                        rdData_d = extData;
                    end
                    state_d = HOLD;
                end else if (cntNext == TOut) begin
                    busErr_d = 1'b1;
                    if (!wrFlag_q) begin
                        rdData_d = 8'hFF;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.memBusy = (state_q != IDLE);
    assign bus.memDone = (state_q == HOLD);
    assign bus.busErr  = busErr_q;
    assign bus.extAddr = addr_q;
    assign bus.extRdN  = !((state_q == STROBE) && !wrFlag_q);
    assign bus.extWrN  = !((state_q == STROBE) && wrFlag_q);

    assign intD    = bus.busDrive ? rdData_q : 8'hzz;
    assign extData = (wrFlag_q && (state_q != IDLE)) ? wrData_q : 8'hzz;

endmodule

// File: tb/tb_r88_busctl.sv
// Bench for r88_busctl: two instances (MIN_WAIT=1/TIMEOUT=15 and
// MIN_WAIT=2/TIMEOUT=6) share stimulus; a scoreboard holds expected cycles.
module tb_r88_busctl;
    logic sysClock = 1'b0;
    logic sysReset;
    always #5 sysClock = ~sysClock;

    logic [15:0] regAddr;
    logic        memReq, memWrite, busDrive, extReady;
    logic [7:0]  intd_v, ext_v;
    logic        intd_en, ext_en;

    wire [7:0] a_intD, b_intD, a_extData, b_extData;
    assign a_intD    = intd_en ? intd_v : 8'hzz;
    assign b_intD    = intd_en ? intd_v : 8'hzz;
    assign a_extData = ext_en ? ext_v : 8'hzz;
    assign b_extData = ext_en ? ext_v : 8'hzz;

    r88_busctl_if a_if ();
    r88_busctl_if b_if ();
    assign a_if.regAddr  = regAddr;
    assign a_if.memReq   = memReq;
    assign a_if.memWrite = memWrite;
    assign a_if.busDrive = busDrive;
    assign a_if.extReady = extReady;
    assign b_if.regAddr  = regAddr;
    assign b_if.memReq   = memReq;
    assign b_if.memWrite = memWrite;
    assign b_if.busDrive = busDrive;
    assign b_if.extReady = extReady;

    r88_busctl #(.MIN_WAIT(1), .TIMEOUT(15)) dut_a (
        .sysClock(sysClock),
        .sysReset(sysReset),
        .bus(a_if),
        .intD(a_intD),
        .extData(a_extData)
    );

    r88_busctl #(.MIN_WAIT(2), .TIMEOUT(6)) dut_b (
        .sysClock(sysClock),
        .sysReset(sysReset),
        .bus(b_if),
        .intD(b_intD),
        .extData(b_extData)
    );

    logic        sel;
    logic        m_busy, m_done, m_err, m_rdn, m_wrn;
    logic [15:0] m_addr;
    logic [7:0]  m_int, m_ext;
    always_comb begin
        m_busy = sel ? b_if.memBusy : a_if.memBusy;
        m_done = sel ? b_if.memDone : a_if.memDone;
        m_err  = sel ? b_if.busErr  : a_if.busErr;
        m_rdn  = sel ? b_if.extRdN  : a_if.extRdN;
        m_wrn  = sel ? b_if.extWrN  : a_if.extWrN;
        m_addr = sel ? b_if.extAddr : a_if.extAddr;
        m_int  = sel ? b_intD       : a_intD;
        m_ext  = sel ? b_extData    : a_extData;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          width;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge sysClock);
        while ((a_if.memBusy || b_if.memBusy) && n < 60) begin
            @(negedge sysClock);
            n++;
        end
        if (n >= 60) chk("idle_budget", n, 0);
    endtask

    task automatic issue(input logic s, input logic wr, input logic [15:0] addr,
                         input logic [7:0] d, input int width, input logic err,
                         input logic [7:0] rd);
        exp_t e;
        wait_idle();
        sel      = s;
        regAddr  = addr;
        memWrite = wr;
        memReq   = 1'b1;
        busDrive = 1'b0;
        intd_en  = 1'b1;
        intd_v   = d;
        ext_en   = !wr;
        ext_v    = d;
        e.wr = wr; e.addr = addr; e.wdata = d;
        e.rdata = rd; e.width = width; e.err = err;
        sb.push_back(e);
    endtask

    // Drives extReady per strobe cycle, then pops and checks at memDone
    task automatic watch(input int ready_after);
        exp_t e;
        int   lowR, lowW, k, cyc;
        logic seen, addr_ok, data_ok;
        lowR = 0; lowW = 0; cyc = 0;
        seen = 1'b0; addr_ok = 1'b1; data_ok = 1'b1;
        e = sb[0];
        @(negedge sysClock);
        chk("err_clr_on_accept", m_err, 0);
        memReq  = 1'b0;
        intd_v  = 8'h00;
        regAddr = ~regAddr;
        while (!seen && cyc < 300) begin
            if (!m_rdn) lowR++;
            if (!m_wrn) lowW++;
            k = lowR + lowW;
            if (!m_rdn || !m_wrn) extReady = (k > ready_after);
            else extReady = (ready_after == 0);
            if (m_addr !== e.addr) addr_ok = 1'b0;
            if (e.wr && m_ext !== e.wdata) data_ok = 1'b0;
            if (m_done) seen = 1'b1;
            else begin
                @(negedge sysClock);
                cyc++;
            end
        end
        chk("done_seen", seen, 1);
        e = sb.pop_front();
        chk("rdn_width", lowR, e.wr ? 0 : e.width);
        chk("wrn_width", lowW, e.wr ? e.width : 0);
        chk("addr_stable", addr_ok, 1);
        chk("wr_data", data_ok, 1);
        chk("bus_err", m_err, e.err);
        chk("busy_in_hold", m_busy, 1);
        @(negedge sysClock);
        chk("done_pulse", m_done, 0);
        chk("busy_idle", m_busy, 0);
        chk("err_sticky", m_err, e.err);
        intd_en  = 1'b0;
        busDrive = 1'b1;
        #1;
        chk("rd_data", m_int, e.rdata);
        busDrive = 1'b0;
        intd_en  = 1'b1;
        #1;
        chk("intd_release", m_int, 8'h00);
    endtask

    initial begin
        int dn;
        sysReset = 1'b1;
        regAddr = 16'h0; memReq = 1'b0; memWrite = 1'b0;
        busDrive = 1'b0; extReady = 1'b0;
        intd_v = 8'h00; intd_en = 1'b1; ext_v = 8'h00; ext_en = 1'b0;
        sel = 1'b0;
        repeat (2) @(negedge sysClock);
        chk("rst_busy", a_if.memBusy, 0);
        chk("rst_done", a_if.memDone, 0);
        chk("rst_err", a_if.busErr, 0);
        chk("rst_addr", a_if.extAddr, 16'h0000);
        chk("rst_rdn", a_if.extRdN, 1);
        chk("rst_wrn", a_if.extWrN, 1);
        chk("rst_b_busy", b_if.memBusy, 0);
        sysReset = 1'b0;

        issue(0, 0, 16'h1234, 8'h5A, 1, 0, 8'h5A);  watch(0);
        issue(0, 1, 16'h8001, 8'hC3, 1, 0, 8'h5A);  watch(0);
        issue(1, 0, 16'h0042, 8'h3C, 4, 0, 8'h3C);  watch(3);
        issue(1, 0, 16'h0043, 8'h77, 2, 0, 8'h77);  watch(0);
        issue(1, 0, 16'h0044, 8'h99, 6, 0, 8'h99);  watch(5);
        issue(1, 1, 16'h0045, 8'h12, 6, 1, 8'h99);  watch(1000);
        issue(1, 0, 16'h0046, 8'h34, 6, 1, 8'hFF);  watch(1000);
        issue(0, 0, 16'h2000, 8'h3C, 1, 0, 8'h3C);  watch(0);
        issue(0, 0, 16'h2001, 8'h55, 15, 1, 8'hFF); watch(1000);
        issue(0, 0, 16'h2002, 8'h66, 1, 0, 8'h66);  watch(0);

        // memReq held high: one cycle every 4 clocks
        wait_idle();
        sel = 1'b0; regAddr = 16'h1111; memWrite = 1'b0; memReq = 1'b1;
        ext_en = 1'b1; ext_v = 8'h21; extReady = 1'b1;
        @(negedge sysClock);
        for (int i = 0; i < 12; i++) begin
            chk("b2b_busy", m_busy, (i % 4) != 3);
            chk("b2b_done", m_done, (i % 4) == 2);
            chk("b2b_addr", m_addr,
                i < 4 ? 16'h1111 : (i < 8 ? 16'h2222 : 16'h3333));
            if (i == 0) regAddr = 16'h2222;
            if (i == 5) regAddr = 16'h3333;
            @(negedge sysClock);
        end
        memReq = 1'b0;

        // reset during the strobe of a write
        wait_idle();
        sel = 1'b0; regAddr = 16'hABCD; memWrite = 1'b1; memReq = 1'b1;
        intd_v = 8'h11; ext_en = 1'b0; extReady = 1'b0;
        @(negedge sysClock);
        memReq = 1'b0;
        dn = 0;
        while (a_if.extWrN && dn < 10) begin
            @(negedge sysClock);
            dn++;
        end
        chk("rst_strobe_reached", a_if.extWrN, 0);
        sysReset = 1'b1;
        ext_en = 1'b1; ext_v = 8'h00;
        @(negedge sysClock);
        sysReset = 1'b0;
        #1;
        chk("rst_mid_wrn", a_if.extWrN, 1);
        chk("rst_mid_busy", a_if.memBusy, 0);
        chk("rst_mid_addr", a_if.extAddr, 16'h0000);
        chk("rst_mid_done", a_if.memDone, 0);
        chk("rst_mid_extdata", a_extData, 8'h00);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysClock);
            if (a_if.memDone) dn++;
        end
        chk("rst_no_done", dn, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
